// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Holds the FSM state encoding, the port numbering used for grants and acks,
// and the default geometry/latency constants used by dmem_arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_MA  = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_MEM_BASE    = 1024;
    localparam int DEF_DEPTH       = 64;

    localparam int IDX_W = 6;   // word index width for DEPTH = 64
    localparam int CNT_W = 4;   // wait-state counter, WAIT_CYCLES in 0..15

endpackage

// File: rtl/dmem_addr_check.sv
// Byte address -> {legal, word index} for the data memory window.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   addr_i   byte address of the access
//   legal_o  1 when MEM_BASE <= addr < MEM_BASE + 4*DEPTH and word aligned
//   idx_o    (addr - MEM_BASE) >> 2, meaningful only when legal_o is 1
module dmem_addr_check
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BASE = DEF_MEM_BASE,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic [31:0]      addr_i,
    output logic             legal_o,
    output logic [IDX_W-1:0] idx_o
);

    // Bounds are compared at 33 bits so an upper limit at the top of the
    // address space cannot wrap around to a small value.
    localparam logic [32:0] LO = 33'(MEM_BASE);
    localparam logic [32:0] HI = 33'(MEM_BASE) + 33'(4 * DEPTH);

    assign legal_o = ({1'b0, addr_i} >= LO) &&
                     ({1'b0, addr_i} <  HI) &&
                     (addr_i[1:0] == 2'b00);

    assign idx_o = IDX_W'((addr_i - 32'(MEM_BASE)) >> 2);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MA stage (port 0) and an aux master (port 1).
// Latency: legal access acks WAIT_CYCLES+2 cycles after the request is seen in IDLE; illegal acks after 1.
// Backpressure: requests are held until ack; a pending MA request raises ma_stall, losers just wait.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   ma_*  / aux_*       req/we/addr/wdata in, ack out (one-cycle pulse); ma_stall = ma_req & ~ma_ack
//   rdata, err          response, valid in the ack cycle (rdata is 0 for writes and errors)
//   mem_r_en, mem_w_en  memory strobes; mem_w_en is a single-cycle pulse per write
//   mem_idx, mem_wdata  latched word index / write data; mem_rdata is combinational from mem_idx
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// MA has fixed priority over AUX.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int MEM_BASE    = DEF_MEM_BASE,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             ma_req,
    input  logic             ma_we,
    input  logic [31:0]      ma_addr,
    input  logic [31:0]      ma_wdata,
    output logic             ma_ack,
    output logic             ma_stall,

    input  logic             aux_req,
    input  logic             aux_we,
    input  logic [31:0]      aux_addr,
    input  logic [31:0]      aux_wdata,
    output logic             aux_ack,

    output logic [31:0]      rdata,
    output logic             err,

    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               port_q, port_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               ma_ack_q, ma_ack_d;
    logic               aux_ack_q, aux_ack_d;
`ifdef DMEM_ARB_RR_EN
    logic               last_q, last_d;
`endif

    logic               any_req;
    logic               win;
    logic               win_we;
    logic [31:0]        win_addr;
    logic [31:0]        win_wdata;
    logic               chk_legal;
    logic [IDX_W-1:0]   chk_idx;

    assign any_req = ma_req | aux_req;

`ifdef DMEM_ARB_RR_EN
    // On contention the port that was not granted last wins; a lone
    // requester always wins.
    assign win = (ma_req && aux_req) ? ~last_q : aux_req;
`else
    assign win = ma_req ? PORT_MA : PORT_AUX;
`endif

    assign win_we    = (win == PORT_AUX) ? aux_we    : ma_we;
    assign win_addr  = (win == PORT_AUX) ? aux_addr  : ma_addr;
    assign win_wdata = (win == PORT_AUX) ? aux_wdata : ma_wdata;

    dmem_addr_check #(
        .MEM_BASE (MEM_BASE),
        .DEPTH    (DEPTH)
    ) u_addr_check (
        .addr_i  (win_addr),
        .legal_o (chk_legal),
        .idx_o   (chk_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ma_ack_d  = 1'b0;
        aux_ack_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_d    = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    port_d  = win;
                    we_d    = win_we;
                    idx_d   = chk_idx;
                    wdata_d = win_wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
`ifdef DMEM_ARB_RR_EN
                    last_d  = win;
`endif
                    if (chk_legal) begin
                        state_d = ST_ACCESS;
                    end else begin
                        // Illegal address: answer straight away, memory untouched.
                        state_d   = ST_RESP;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                        ma_ack_d  = (win == PORT_MA);
                        aux_ack_d = (win == PORT_AUX);
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d   = ST_RESP;
                    err_d     = 1'b0;
                    rdata_d   = we_q ? 32'h0 : mem_rdata;
                    ma_ack_d  = (port_q == PORT_MA);
                    aux_ack_d = (port_q == PORT_AUX);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RESP: begin
                // Ack cycle; no grant is made here so acks never abut.
                state_d = ST_IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_MA;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            ma_ack_q  <= 1'b0;
            aux_ack_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_q    <= PORT_AUX;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            ma_ack_q  <= ma_ack_d;
            aux_ack_q <= aux_ack_d;
`ifdef DMEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign ma_ack    = ma_ack_q;
    assign aux_ack   = aux_ack_q;
    assign ma_stall  = ma_req & ~ma_ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

    // Reads strobe for the whole access; the write strobe fires only in the
    // final wait cycle so each write lands exactly once.
    assign mem_r_en  = (state_q == ST_ACCESS) && !we_q;
    assign mem_w_en  = (state_q == ST_ACCESS) && we_q && (cnt_q == '0);
    assign mem_idx   = idx_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (WAIT_CYCLES=1 main instance, WAIT_CYCLES=3 abort instance).
// Latency expectations come from a transaction-level reference model.
// Backpressure: requests are held until ack, as the requester contract demands.
module tb_dmem_arbiter;

    localparam int          W    = 1;
    localparam int          W3   = 3;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          NW   = 64;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst = 1'b0;
    logic        ma_req = 0, ma_we = 0, aux_req = 0, aux_we = 0;
    logic [31:0] ma_addr = 0, ma_wdata = 0, aux_addr = 0, aux_wdata = 0;
    logic        ma_ack, ma_stall, aux_ack, err, mem_r_en, mem_w_en;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [5:0]  mem_idx;

    // abort instance
    logic        rst3 = 1'b0;
    logic        aux_req3 = 0, aux_we3 = 0;
    logic [31:0] aux_addr3 = 0, aux_wdata3 = 0;
    logic        ma_ack3, ma_stall3, aux_ack3, err3, mem_r_en3, mem_w_en3;
    logic [31:0] rdata3, mem_wdata3, mem_rdata3;
    logic [5:0]  mem_idx3;

    dmem_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_ack(ma_ack), .ma_stall(ma_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack),
        .rdata(rdata), .err(err),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_idx(mem_idx),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.WAIT_CYCLES(W3)) dut3 (
        .clk(clk), .rst(rst3),
        .ma_req(1'b0), .ma_we(1'b0), .ma_addr(32'h0), .ma_wdata(32'h0),
        .ma_ack(ma_ack3), .ma_stall(ma_stall3),
        .aux_req(aux_req3), .aux_we(aux_we3), .aux_addr(aux_addr3), .aux_wdata(aux_wdata3),
        .aux_ack(aux_ack3),
        .rdata(rdata3), .err(err3),
        .mem_r_en(mem_r_en3), .mem_w_en(mem_w_en3), .mem_idx(mem_idx3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    function automatic logic [31:0] pat(int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0107);
    endfunction

    // SRAM behind the main instance
    logic [31:0] sram [NW];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NW; i++) sram[i] <= pat(i);
        end else if (mem_w_en) begin
            sram[mem_idx] <= mem_wdata;
        end
    end
    assign mem_rdata  = sram[mem_idx];
    assign mem_rdata3 = 32'hAAAA_AA00 + 32'(mem_idx3);

    // Reference model: memory contents as seen by completed transactions.
    logic [31:0] ref_mem [NW];

    function automatic bit ref_legal(logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * NW)) && (a % 4 == 0);
    endfunction

    // Issue one access on one port and observe it until its ack.
    task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [5:0] exp_idx,
                             output int lat, output logic [31:0] rd, output logic e,
                             output int nwr, output int nrd, output int bad_stall,
                             output int bad_idx, output int other_ack);
        logic a;
        lat = -1; rd = '0; e = 1'b0; nwr = 0; nrd = 0;
        bad_stall = 0; bad_idx = 0; other_ack = 0;
        if (port == 1'b0) begin
            ma_req = 1; ma_we = we; ma_addr = addr; ma_wdata = wd;
        end else begin
            aux_req = 1; aux_we = we; aux_addr = addr; aux_wdata = wd;
        end
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            a = port ? aux_ack : ma_ack;
            if (mem_w_en) nwr++;
            if (mem_r_en) nrd++;
            if ((mem_w_en || mem_r_en) && mem_idx !== exp_idx) bad_idx++;
            if ((port ? ma_ack : aux_ack) !== 1'b0) other_ack++;
            if (ma_stall !== ((port == 1'b0) && !a)) bad_stall++;
            if (a) begin
                lat = c; rd = rdata; e = err;
            end else begin
                @(posedge clk); #1;
            end
        end
        ma_req = 0; aux_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ma_ack, aux_ack, err, ma_stall} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {ma_ack, aux_ack, err, ma_stall});
        end
        checks++;
        if ({mem_r_en, mem_w_en} !== 2'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_r_en, mem_w_en});
        end
        checks++;
        if ({rdata, mem_wdata, mem_idx} !== 70'h0) begin
            failures++; $display("FAIL reset_buses rdata=%h wdata=%h idx=%0d exp=0", rdata, mem_wdata, mem_idx);
        end
        rst = 1; rst3 = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat, nwr, nrd, bs, bi, oa; logic [31:0] rd; logic e;
        do_access(0, 1, 32'h400, 32'hDEADBEEF, 6'd0, lat, rd, e, nwr, nrd, bs, bi, oa);
        ref_mem[0] = 32'hDEADBEEF;
        checks++;
        if (lat !== W + 2 || e !== 1'b0) begin
            failures++; $display("FAIL wr_ack lat=%0d err=%b exp lat=%0d err=0", lat, e, W + 2);
        end
        checks++;
        if (nwr !== 1 || bi !== 0 || bs !== 0 || oa !== 0) begin
            failures++; $display("FAIL wr_pulse nwr=%0d badidx=%0d badstall=%0d other=%0d exp 1/0/0/0", nwr, bi, bs, oa);
        end
        do_access(0, 0, 32'h400, 32'h0, 6'd0, lat, rd, e, nwr, nrd, bs, bi, oa);
        checks++;
        if (lat !== W + 2 || rd !== ref_mem[0] || e !== 1'b0) begin
            failures++; $display("FAIL rd_back lat=%0d rdata=%h err=%b exp lat=%0d rdata=%h", lat, rd, e, W + 2, ref_mem[0]);
        end
        checks++;
        if (nrd !== W + 1 || nwr !== 0) begin
            failures++; $display("FAIL rd_strobes nrd=%0d nwr=%0d exp %0d/0", nrd, nwr, W + 1);
        end
    endtask

    task automatic test_range();
        int lat, nwr, nrd, bs, bi, oa; logic [31:0] rd; logic e;
        do_access(0, 0, 32'h4FC, 32'h0, 6'd63, lat, rd, e, nwr, nrd, bs, bi, oa);
        checks++;
        if (lat !== W + 2 || rd !== ref_mem[63] || e !== 1'b0 || bi !== 0 || nrd !== W + 1) begin
            failures++; $display("FAIL top_word lat=%0d rdata=%h err=%b badidx=%0d nrd=%0d exp rdata=%h", lat, rd, e, bi, nrd, ref_mem[63]);
        end
        do_access(0, 0, 32'h500, 32'h0, 6'd0, lat, rd, e, nwr, nrd, bs, bi, oa);
        checks++;
        if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || nrd !== 0) begin
            failures++; $display("FAIL past_end lat=%0d err=%b rdata=%h nrd=%0d exp 1/1/0/0", lat, e, rd, nrd);
        end
    endtask

    task automatic test_misaligned();
        int lat, nwr, nrd, bs, bi, oa; logic [31:0] rd; logic e;
        do_access(0, 1, 32'h402, 32'h1234_5678, 6'd0, lat, rd, e, nwr, nrd, bs, bi, oa);
        checks++;
        if (lat !== 1 || e !== 1'b1 || nwr !== 0) begin
            failures++; $display("FAIL misaligned lat=%0d err=%b nwr=%0d exp 1/1/0", lat, e, nwr);
        end
        checks++;
        if (bs !== 0) begin
            failures++; $display("FAIL misaligned_stall bad_cycles=%0d exp 0", bs);
        end
    endtask

    task automatic test_arbitration();
        bit pend[2]; bit ptr; bit w; int n_exp; int exp_port[3];
        int got_port[$]; int got_cyc[$]; int both; logic stall1;
        both = 0; stall1 = 1'bx; n_exp = 0;
        pend[0] = 1; pend[1] = 1; ptr = 1;
        for (int k = 0; k < 3; k++) begin
            if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) w = RR ? !ptr : 1'b0;
                else                    w = pend[0] ? 1'b0 : 1'b1;
                exp_port[k] = int'(w); ptr = w; n_exp++;
                if (!RR) pend[w] = 0;
            end
        end
        ma_req = 1; ma_we = 0; ma_addr = 32'h40C;
        aux_req = 1; aux_we = 0; aux_addr = 32'h410;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 1) stall1 = ma_stall;
            if (ma_ack && aux_ack) both++;
            if (ma_ack || aux_ack) begin
                got_port.push_back(aux_ack ? 1 : 0);
                got_cyc.push_back(c);
                if (!RR) begin
                    if (ma_ack)  ma_req = 0;
                    if (aux_ack) aux_req = 0;
                end else if (got_port.size() == 3) begin
                    ma_req = 0; aux_req = 0;
                end
            end
            @(posedge clk); #1;
        end
        ma_req = 0; aux_req = 0;
        checks++;
        if (got_port.size() !== n_exp || both !== 0) begin
            failures++; $display("FAIL arb_count acks=%0d both=%0d exp %0d/0", got_port.size(), both, n_exp);
        end
        for (int k = 0; k < n_exp && k < got_port.size(); k++) begin
            checks++;
            if (got_port[k] !== exp_port[k] || got_cyc[k] !== k * (W + 3) + W + 2) begin
                failures++; $display("FAIL arb_grant%0d port=%0d cyc=%0d exp port=%0d cyc=%0d", k, got_port[k], got_cyc[k], exp_port[k], k * (W + 3) + W + 2);
            end
        end
        checks++;
        if (stall1 !== 1'b1) begin
            failures++; $display("FAIL arb_stall got=%b exp=1", stall1);
        end
    endtask

    task automatic test_reset_abort();
        int wr = 0; int acks = 0; int lat = -1; logic [31:0] rd = '0;
        aux_req3 = 1; aux_we3 = 1; aux_addr3 = 32'h410; aux_wdata3 = $urandom;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (mem_w_en3) wr++;
            if (aux_ack3 || ma_ack3) acks++;
            @(posedge clk); #1;
        end
        rst3 = 0; aux_req3 = 0;
        #1;
        checks++;
        if ({aux_ack3, ma_ack3, err3, mem_r_en3, mem_w_en3, ma_stall3} !== 6'b0) begin
            failures++; $display("FAIL abort_flags got=%b exp=000000", {aux_ack3, ma_ack3, err3, mem_r_en3, mem_w_en3, ma_stall3});
        end
        checks++;
        if ({rdata3, mem_wdata3, mem_idx3} !== 70'h0) begin
            failures++; $display("FAIL abort_buses rdata=%h wdata=%h idx=%0d exp=0", rdata3, mem_wdata3, mem_idx3);
        end
        repeat (3) begin
            @(negedge clk);
            if (mem_w_en3) wr++;
            if (aux_ack3 || ma_ack3) acks++;
        end
        rst3 = 1;
        repeat (6) begin
            @(negedge clk);
            if (mem_w_en3) wr++;
            if (aux_ack3 || ma_ack3) acks++;
        end
        checks++;
        if (wr !== 0 || acks !== 0) begin
            failures++; $display("FAIL abort_quiet writes=%0d acks=%0d exp 0/0", wr, acks);
        end
        @(posedge clk); #1;
        aux_req3 = 1; aux_we3 = 0; aux_addr3 = 32'h404;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (aux_ack3) begin
                lat = c; rd = rdata3;
            end else begin
                @(posedge clk); #1;
            end
        end
        aux_req3 = 0;
        @(posedge clk); #1;
        checks++;
        if (lat !== W3 + 2 || rd !== 32'hAAAA_AA01) begin
            failures++; $display("FAIL abort_restart lat=%0d rdata=%h exp lat=%0d rdata=aaaaaa01", lat, rd, W3 + 2);
        end
    endtask

    task automatic test_back_to_back();
        int acks[$]; int prev = -10; int consec = 0; int badrd = 0; int badgap = 0;
        ma_req = 1; ma_we = 0; ma_addr = 32'h408;
        for (int c = 0; c < 60 && acks.size() < 9; c++) begin
            @(negedge clk);
            if (ma_ack) begin
                if (prev == c - 1) consec++;
                prev = c;
                acks.push_back(c);
                if (rdata !== ref_mem[2]) badrd++;
                if (acks.size() == 9) ma_req = 0;
            end
            @(posedge clk); #1;
        end
        ma_req = 0;
        for (int k = 1; k < acks.size(); k++)
            if (acks[k] - acks[k-1] !== W + 3) badgap++;
        checks++;
        if (acks.size() !== 9 || acks.size() > 0 && acks[0] !== W + 2) begin
            failures++; $display("FAIL b2b_count acks=%0d first=%0d exp 9 first=%0d", acks.size(), acks.size() > 0 ? acks[0] : -1, W + 2);
        end
        checks++;
        if (badgap !== 0 || consec !== 0) begin
            failures++; $display("FAIL b2b_spacing bad_gaps=%0d consecutive=%0d exp 0/0", badgap, consec);
        end
        checks++;
        if (badrd !== 0) begin
            failures++; $display("FAIL b2b_rdata bad=%0d exp 0", badrd);
        end
    endtask

    task automatic test_random();
        int lat, nwr, nrd, bs, bi, oa; logic [31:0] rd; logic e;
        bit port, we, legal; int kind; logic [31:0] addr, wd, exp_rd; logic [5:0] idx;
        for (int t = 0; t < 60; t++) begin
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 5);
            wd   = $urandom;
            case (kind)
                3:       addr = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
                4:       addr = BASE + 32'(4 * NW) + 32'(4 * $urandom_range(0, 4000));
                5:       addr = ($urandom_range(0, 1) == 1) ? 32'(4 * $urandom_range(0, 255))
                                                            : 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 3));
                default: addr = BASE + 32'(4 * $urandom_range(0, 63));
            endcase
            legal  = ref_legal(addr);
            idx    = 6'((addr - BASE) / 4);
            exp_rd = (legal && !we) ? ref_mem[idx] : 32'h0;
            do_access(port, we, addr, wd, idx, lat, rd, e, nwr, nrd, bs, bi, oa);
            if (legal && we) ref_mem[idx] = wd;
            checks++;
            if (lat !== (legal ? W + 2 : 1) || e !== !legal) begin
                failures++; $display("FAIL rnd%0d_ack addr=%h lat=%0d err=%b exp lat=%0d err=%b", t, addr, lat, e, legal ? W + 2 : 1, !legal);
            end
            checks++;
            if (rd !== exp_rd) begin
                failures++; $display("FAIL rnd%0d_rdata addr=%h got=%h exp=%h", t, addr, rd, exp_rd);
            end
            checks++;
            if (nwr !== ((legal && we) ? 1 : 0) || nrd !== ((legal && !we) ? W + 1 : 0)) begin
                failures++; $display("FAIL rnd%0d_strobes nwr=%0d nrd=%0d legal=%b we=%b", t, nwr, nrd, legal, we);
            end
            checks++;
            if (bs !== 0 || bi !== 0 || oa !== 0) begin
                failures++; $display("FAIL rnd%0d_side port=%0d badstall=%0d badidx=%0d other=%0d exp 0/0/0", t, port, bs, bi, oa);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) ref_mem[i] = pat(i);
        test_reset();
        test_write_read();
        test_range();
        test_misaligned();
        test_arbitration();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
